// File: rtl/apb_regbank.sv
// apb_regbank: APB slave register bank with byte strobes, programmable wait states,
// hardware-fed read-only registers and address/protection error responses.
module apb_regbank #(
    parameter int unsigned         DATA_WIDTH  = 32,
    parameter int unsigned         ADDR_WIDTH  = 32,
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter bit                  PRIV_ONLY   = 1'b0
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned ALSB   = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int unsigned IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned SPAN   = NUM_REGS * NBYTES;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALSB) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IDXW-1:0]       r_idx;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NBYTES-1:0]     r_strb;
    logic                  r_err;
    logic                  r_pready;
    logic                  r_pslverr;
    logic                  r_rd_ok;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [IDXW-1:0]       w_setup_idx;
    logic                  w_ro_hit;
    logic                  w_oob;
    logic                  w_misalign;
    logic                  w_setup_err;
    logic                  w_setup;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_unused    = ^pprot[2:1];
    assign w_setup     = psel && !penable;
    assign w_setup_idx = paddr[ALSB +: IDXW];
    assign w_oob       = (64'(paddr) >= 64'(SPAN));
    assign w_misalign  = |(paddr & ALIGN_MASK);

    always_comb begin
        w_ro_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_setup_idx == IDXW'(i)) w_ro_hit = RO_MASK[i];
        end
    end

    // The error decision depends only on setup-phase values, so it is resolved at
    // capture time and pprot[0] is folded into r_err rather than stored separately.
    assign w_setup_err = w_oob || w_misalign || (pwrite && w_ro_hit) ||
                         (PRIV_ONLY && !pprot[0]);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_ok   <= 1'b0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_ok   <= 1'b0;
            unique case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_setup) begin
                        r_idx   <= w_setup_idx;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        r_strb  <= pstrb;
                        r_err   <= w_setup_err;
                        r_cnt   <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            r_state   <= S_RESP;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_setup_err;
                            r_rd_ok   <= !w_setup_err && !pwrite;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state   <= S_RESP;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_rd_ok   <= !r_err && !r_write;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_commit = (r_state == S_RESP) && psel && r_write && !r_err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (r_idx == IDXW'(i) && !RO_MASK[i]) begin
                    for (int unsigned b = 0; b < NBYTES; b++) begin
                        if (r_strb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read data is muxed live from storage so a write committed on the edge that
    // starts a back-to-back read is already visible in that read's RESP cycle.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_rdata = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_rd_ok ? w_rdata : '0;

endmodule
